digit_serial_adder: RTL and testbench
=====================================

Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle add/subtract unit for the LEGv8 datapath.
- Processes a WIDTH-bit operation DIGIT bits per clock, rippling the carry through a registered carry flop.
- Produces the result together with the LEGv8 condition flags N, Z, C and V.
- Uses a valid/ready handshake on input and output. It serves as the area-lean ALU adder path and the ADDS/SUBS flag source.

Parameters:
- WIDTH, 64, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 8, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH.
- NUM_DIGITS, WIDTH/DIGIT, derived localparam; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and mode presented
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0 = A+B, 1 = A−B
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer takes the result
- result  output  WIDTH  sum or difference
- flag_n  output  1  result[WIDTH-1]
- flag_z  output  1  result == 0
- flag_c  output  1  carry out of the MSB; for SUB, 1 = no borrow
- flag_v  output  1  signed overflow

Behaviour:
- Reset, asynchronous and active-high:
  - State goes to IDLE.
  - in_ready=1, out_valid=0.
  - result=0 and all flags=0.
  - The digit counter and the carry flop clear.
  - Applies at any time, including mid-RUN or in DONE. Any in-flight operation is discarded with no output.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready:
    - Latch a.
    - Latch b, inverted when sub=1.
    - Set carry = sub.
    - Set counter = 0 and go to RUN.
- State RUN:
  - in_ready=0.
  - Each cycle, add digit[counter] of A, digit[counter] of B' and carry.
  - Write the DIGIT-bit sum into the result register at digit position counter.
  - Register the carry-out and increment counter.
  - On the final digit (counter == NUM_DIGITS-1):
    - flag_c = digit carry-out.
    - flag_v = carry into MSB XOR carry out of MSB.
    - Go to DONE.
- State DONE:
  - out_valid=1.
  - N and Z are driven combinationally from the result register.
  - Hold result and flags stable while out_ready=0, for an unbounded time.
  - On out_ready=1, go to IDLE.
  - in_valid is ignored while in DONE; there is no same-cycle accept-on-drain.
- Latency:
  - Accept edge, then out_valid rises exactly NUM_DIGITS cycles later.
  - Throughput is one operation per NUM_DIGITS+2 cycles when out_ready is held high.
- Arithmetic:
  - Modulo 2^WIDTH; no saturation.
  - Carry-in is used only for SUB.
- DIGIT = WIDTH: RUN lasts one cycle.
- DIGIT = 1: pure bit-serial.
- Operand inputs are sampled only on the accept edge. Changes afterwards have no effect.
- Intermediate result bits are not guaranteed until DONE. Output flags update only on entering DONE.

Decomposition:
- Shared package (ALU constants): state encodings S_IDLE, S_RUN and S_DONE; the op-mode encoding (OP_ADD=0, OP_SUB=1); flag bit indices (N=3, Z=2, C=1, V=0) for the flags-register consumer.
- One sub-module: digit_adder.
  - Combinational, DIGIT-wide ripple adder.
  - Inputs: x, y, cin. Outputs: s, cout, and c_msb_in, the carry into the top bit, used for V.
  - Built as a chain of full adders composed from the existing half-adder cells.

Test Plan:
- WIDTH=64, DIGIT=8: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 → result=0, Z=1, C=1, N=0, V=0; out_valid exactly 8 cycles after the accept edge.
- sub=1, a=5, b=7 → result=0xFFFF_FFFF_FFFF_FFFE, N=1, C=0 (borrow), Z=0, V=0. Then a=7, b=5 → result=2, C=1.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 → result=0x8000_0000_0000_0000, N=1, V=1, C=0.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid and toggle a, b and in_valid → result and flags unchanged, in_ready=0. Release → IDLE, then a second op is accepted.
- Reset pulse mid-RUN (after the third digit) → out_valid=0 and in_ready=1 immediately. The next op (0x1234+0x4321) yields 0x5555 with no residue.
- Re-elaborate with DIGIT=1 and DIGIT=64 → latency 64 and 1 respectively. Random ADD/SUB results match a reference model over 1000 ops.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared ALU constants for the digit-serial add/subtract path: FSM states,
// op-mode encoding, flag-register bit positions and the half-adder cell.
package digit_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Half-adder cell: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic i_x, input logic i_y);
      return {i_x & i_y, i_x ^ i_y};
   endfunction

endpackage

// File: rtl/digit_serial_adder_digit.sv
// DIGIT-wide ripple adder built from full adders, each made of two half-adder
// cells. Also exposes the carry into the top bit for overflow detection.
module digit_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      logic [1:0] w_h1;
      logic [1:0] w_h2;
      assign w_h1       = half_add(x[i], y[i]);
      assign w_h2       = half_add(w_h1[0], w_c[i]);
      assign s[i]       = w_h2[0];
      assign w_c[i + 1] = w_h1[1] | w_h2[1];
   end

   assign cout     = w_c[DIGIT];
   assign c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock through a
// registered carry, then presents result and N/Z/C/V behind valid/ready.
module digit_serial_adder
   import digit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int NUM_DIGITS = WIDTH / DIGIT;
   localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

   state_t                 r_state;
   state_t                 w_next;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-1:0]       r_result;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_carry;
   logic                   r_c;
   logic                   r_v;
   logic                   r_live;
   logic [DIGIT-1:0]       w_sum;
   logic                   w_cout;
   logic                   w_msb_in;
   logic [WIDTH+DIGIT-1:0] w_res_cat;
   logic                   w_accept;
   logic                   w_last;

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .x        (r_a[DIGIT-1:0]),
      .y        (r_b[DIGIT-1:0]),
      .cin      (r_carry),
      .s        (w_sum),
      .cout     (w_cout),
      .c_msb_in (w_msb_in)
   );

   assign w_accept  = in_valid && (r_state == S_IDLE);
   assign w_last    = (r_cnt == LAST_CNT);
   // Operands shift down one digit per cycle; sums enter the result from the top.
   assign w_res_cat = {w_sum, r_result};

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_RUN;
         end
         S_RUN: begin
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_live   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= (sub == OP_SUB) ? ~b : b;
         r_carry <= sub;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a      <= r_a >> DIGIT;
         r_b      <= r_b >> DIGIT;
         r_result <= w_res_cat[WIDTH+DIGIT-1:DIGIT];
         r_carry  <= w_cout;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_c    <= w_cout;
            r_v    <= w_cout ^ w_msb_in;
            r_live <= 1'b1;
         end
      end
   end

   // N/Z stay low out of reset until a first result has been produced.
   assign result = r_result;
   assign flag_n = r_live & r_result[WIDTH-1];
   assign flag_z = r_live & (r_result == '0);
   assign flag_c = r_c;
   assign flag_v = r_v;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: driver pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_digit_serial_adder;

   localparam int WIDTH = 64;
   parameter  int DIGIT = 8;
   localparam int ND    = WIDTH / DIGIT;

   typedef struct packed {
      logic [WIDTH-1:0] r;
      logic             n;
      logic             z;
      logic             c;
      logic             v;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_n;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic exp_t mk(input logic [WIDTH-1:0] r, input logic n, input logic z,
                               input logic c, input logic v);
      exp_t e;
      e.r = r; e.n = n; e.z = z; e.c = c; e.v = v;
      return e;
   endfunction

   // Plain-arithmetic reference: unsigned compare for borrow, sign rules for overflow.
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic s);
      exp_t           e;
      logic [WIDTH:0] full;
      if (s) begin
         e.r = x - y;
         e.c = (x >= y);
         e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
      end else begin
         full = {1'b0, x} + {1'b0, y};
         e.r  = full[WIDTH-1:0];
         e.c  = full[WIDTH];
         e.v  = (x[WIDTH-1] == y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
      end
      e.n = e.r[WIDTH-1];
      e.z = (e.r == '0);
      return e;
   endfunction

   function automatic logic [WIDTH-1:0] rnd64();
      logic [WIDTH-1:0] v;
      v = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b0, {(WIDTH-1){1'b1}}};
         3: v = {1'b1, {(WIDTH-1){1'b0}}};
         default: ;
      endcase
      return v;
   endfunction

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, got, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t got;
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         got = {result, flag_n, flag_z, flag_c, flag_v};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected no output", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_bad++;
               $display("FAIL result_flags: got %h, expected %h", got, e);
            end
         end
      end
   end

   task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                        input exp_t e, input int hold);
      int cyc;
      out_ready = (hold == 0);
      cyc = 0;
      while (!in_ready && cyc < 4 * ND + 10) begin
         @(posedge clk); #1; cyc++;
      end
      check("accept_ready", 128'(in_ready), 128'(1));
      a = x; b = y; sub = s; in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
      in_valid = 1'b0; a = rnd64(); b = rnd64(); sub = 1'($urandom());
      cyc = 0;
      while (!out_valid && cyc < ND + 4) begin
         @(posedge clk); #1; cyc++;
      end
      check("latency", 128'(cyc), 128'(ND));
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'($urandom()); a = rnd64(); b = rnd64(); sub = 1'($urandom());
         @(posedge clk); #1;
         check("hold_stable", {in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v},
               {1'b0, 1'b1, e.r, e.n, e.z, e.c, e.v});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("drain_idle", {in_ready, out_valid}, {1'b1, 1'b0});
   endtask

   initial begin
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic             s;
      int               cyc;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v},
            {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000});
      rst = 1'b0;
      @(posedge clk); #1;

      do_op('1, 64'd1, 1'b0, mk('0, 1'b0, 1'b1, 1'b1, 1'b0), 0);
      do_op(64'd5, 64'd7, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0), 0);
      do_op(64'd7, 64'd5, 1'b1, mk(64'd2, 1'b0, 1'b0, 1'b1, 1'b0), 0);
      do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
            mk(64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 1'b1), 0);
      do_op(64'd3, 64'd4, 1'b0, mk(64'd7, 1'b0, 1'b0, 1'b0, 1'b0), 5);
      do_op(64'd10, 64'd20, 1'b0, mk(64'd30, 1'b0, 1'b0, 1'b0, 1'b0), 0);

      // Abort an operation partway through RUN; nothing may come out of it.
      out_ready = 1'b1;
      cyc = 0;
      while (!in_ready && cyc < 4 * ND + 10) begin
         @(posedge clk); #1; cyc++;
      end
      a = '1; b = '1; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat ((ND > 3) ? 3 : 0) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("reset_mid_run", {in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v},
            {1'b1, 1'b0, {WIDTH{1'b0}}, 4'b0000});
      @(posedge clk); #1;
      rst = 1'b0;
      do_op(64'h1234, 64'h4321, 1'b0, mk(64'h5555, 1'b0, 1'b0, 1'b0, 1'b0), 0);

      for (int i = 0; i < 1000; i++) begin
         x = rnd64();
         y = rnd64();
         s = 1'($urandom());
         do_op(x, y, s, model(x, y, s), $urandom_range(0, 2));
      end

      repeat (2) @(posedge clk);
      #1;
      check("queue_empty", 128'(exp_q.size()), 128'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
